// File: rtl/servo_pkg.sv
// Shared types, constants and width helpers for the servo L/M/N front end.
package servo_pkg;

   localparam int TW = 8;   // trig table entry width, signed Q1.6
   localparam int QF = 6;   // fraction bits of the trig tables

   // Six legs at 0/60/120/180/240/300 degrees, channel 0 in the LSBs.
   localparam logic [6*TW-1:0] COS_TBL_DEF = 48'h20_E0_C0_E0_20_40;
   localparam logic [6*TW-1:0] SIN_TBL_DEF = 48'hC9_C9_00_37_37_00;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_WAIT = 2'd2
   } state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int x = v - 1; x > 0; x = x >> 1) r++;
      return r;
   endfunction

   function automatic int calc_cw(input int nch);
      int c;
      c = clog2(nch);
      return (c < 1) ? 1 : c;
   endfunction

   function automatic int calc_ow(input int w, input int aw);
      return 2 * w + aw;
   endfunction

endpackage

// File: rtl/lmn_pipe.sv
// Two-stage enable-gated L/M/N arithmetic: P1 forms products, P2 forms sums and the Q1.6 shift.
module lmn_pipe
   import servo_pkg::*;
#(
   parameter int              W  = 9,
   parameter int              AW = 8,
   parameter logic [AW-1:0]   A  = 20,
   parameter logic [2*W-1:0]  K  = 100,
   parameter int              OW = 2 * W + AW,
   parameter int              CW = 3
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 i_valid,
   input  logic [CW-1:0]        i_tag,
   input  logic signed [W-1:0]  i_lx,
   input  logic signed [W-1:0]  i_ly,
   input  logic signed [W-1:0]  i_lz,
   input  logic signed [TW-1:0] i_cos,
   input  logic signed [TW-1:0] i_sin,
   output logic                 o_valid,
   output logic [CW-1:0]        o_tag,
   output logic signed [OW-1:0] o_l,
   output logic signed [OW-1:0] o_m,
   output logic signed [OW-1:0] o_n
);

   // The N path needs TW extra bits of headroom before the shift brings it back into OW.
   localparam int NW = OW + TW;
   localparam logic signed [OW-1:0] K_E     = OW'(K);
   localparam logic signed [OW-1:0] TWO_A_O = OW'({1'b0, A, 1'b0});
   localparam logic signed [NW-1:0] TWO_A_N = NW'({1'b0, A, 1'b0});

   logic signed [OW-1:0] w_lx, w_ly, w_lz;
   logic signed [NW-1:0] w_cx, w_sy, w_nfull;

   logic                 r_p1_valid, r_p2_valid;
   logic [CW-1:0]        r_p1_tag, r_p2_tag;
   logic signed [OW-1:0] r_lx2, r_ly2, r_lz2, r_m1;
   logic signed [NW-1:0] r_cx, r_sy;
   logic signed [OW-1:0] r_l, r_m2, r_n;

   assign w_lx    = OW'(i_lx);
   assign w_ly    = OW'(i_ly);
   assign w_lz    = OW'(i_lz);
   assign w_cx    = NW'(i_cos) * NW'(i_lx);
   assign w_sy    = NW'(i_sin) * NW'(i_ly);
   assign w_nfull = (r_cx + r_sy) * TWO_A_N;

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_p1_valid <= 1'b0;
         r_p2_valid <= 1'b0;
      end else if (en) begin
         r_p1_valid <= i_valid;
         r_p2_valid <= r_p1_valid;
      end
   end

   // NOTE: datapath registers carry no reset; the valid bits alone qualify them.
   always_ff @(posedge clock) begin
      if (en) begin
         r_p1_tag <= i_tag;
         r_lx2    <= w_lx * w_lx;
         r_ly2    <= w_ly * w_ly;
         r_lz2    <= w_lz * w_lz;
         r_m1     <= w_lz * TWO_A_O;
         r_cx     <= w_cx;
         r_sy     <= w_sy;

         r_p2_tag <= r_p1_tag;
         r_l      <= r_lx2 + r_ly2 + r_lz2 - K_E;
         r_m2     <= r_m1;
         r_n      <= OW'(w_nfull >>> QF);
      end
   end

   assign o_valid = r_p2_valid;
   assign o_tag   = r_p2_tag;
   assign o_l     = r_l;
   assign o_m     = r_m2;
   assign o_n     = r_n;

endmodule

// File: rtl/servo_lmn_seq.sv
// Frame-serial L/M/N front end: captures NCH leg vectors and streams tagged per-leg results.
module servo_lmn_seq
   import servo_pkg::*;
#(
   parameter int                NCH     = 6,
   parameter int                W       = 9,
   parameter int                AW      = 8,
   parameter logic [AW-1:0]     A       = 20,
   parameter logic [2*W-1:0]    K       = 100,
   parameter logic [TW*NCH-1:0] COS_TBL = COS_TBL_DEF,
   parameter logic [TW*NCH-1:0] SIN_TBL = SIN_TBL_DEF,
   localparam int               OW      = calc_ow(W, AW),
   localparam int               CW      = calc_cw(NCH)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 frame_valid,
   output logic                 frame_ready,
   input  logic [NCH*W-1:0]     lx_flat,
   input  logic [NCH*W-1:0]     ly_flat,
   input  logic [NCH*W-1:0]     lz_flat,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CW-1:0]        out_ch,
   output logic                 out_last,
   output logic signed [OW-1:0] L,
   output logic signed [OW-1:0] M,
   output logic signed [OW-1:0] N,
   output logic                 busy
);

   state_e               r_state;
   logic                 r_frame_ready, r_busy;
   logic [CW-1:0]        r_ch;
   logic signed [W-1:0]  r_lx [NCH];
   logic signed [W-1:0]  r_ly [NCH];
   logic signed [W-1:0]  r_lz [NCH];

   logic                 r_out_valid, r_out_last;
   logic [CW-1:0]        r_out_ch;
   logic signed [OW-1:0] r_l, r_m, r_n;

   logic                 w_en, w_issue, w_accept;
   logic signed [W-1:0]  w_lx, w_ly, w_lz;
   logic signed [TW-1:0] w_cos, w_sin;
   logic                 w_p2_valid;
   logic [CW-1:0]        w_p2_tag;
   logic signed [OW-1:0] w_p2_l, w_p2_m, w_p2_n;

   // A held result freezes the pipeline, the issue counter and the FSM together.
   assign w_en     = !(r_out_valid && !out_ready);
   assign w_issue  = (r_state == ST_RUN);
   assign w_accept = (r_state == ST_IDLE) && frame_valid && w_en;

   always_ff @(posedge clock) begin
      if (w_accept) begin
         for (int i = 0; i < NCH; i++) begin
            r_lx[i] <= lx_flat[i*W +: W];
            r_ly[i] <= ly_flat[i*W +: W];
            r_lz[i] <= lz_flat[i*W +: W];
         end
      end
   end

   // NOTE: defaults first so every path assigns and no latch is inferred.
   always_comb begin
      w_lx  = '0;
      w_ly  = '0;
      w_lz  = '0;
      w_cos = '0;
      w_sin = '0;
      for (int i = 0; i < NCH; i++) begin
         if (r_ch == CW'(i)) begin
            w_lx  = r_lx[i];
            w_ly  = r_ly[i];
            w_lz  = r_lz[i];
            w_cos = COS_TBL[i*TW +: TW];
            w_sin = SIN_TBL[i*TW +: TW];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_frame_ready <= 1'b1;
         r_busy        <= 1'b0;
         r_ch          <= '0;
      end else if (w_en) begin
         case (r_state)
            ST_IDLE: begin
               if (frame_valid) begin
                  r_state       <= ST_RUN;
                  r_ch          <= '0;
                  r_frame_ready <= 1'b0;
                  r_busy        <= 1'b1;
               end
            end
            ST_RUN: begin
               if (r_ch == CW'(NCH - 1)) r_state <= ST_WAIT;
               else                      r_ch    <= r_ch + CW'(1);
            end
            ST_WAIT: begin
               if (r_out_valid && out_ready && r_out_last) begin
                  r_state       <= ST_IDLE;
                  r_frame_ready <= 1'b1;
                  r_busy        <= 1'b0;
               end
            end
            default: begin
               r_state       <= ST_IDLE;
               r_frame_ready <= 1'b1;
               r_busy        <= 1'b0;
            end
         endcase
      end
   end

   lmn_pipe #(
      .W  (W),
      .AW (AW),
      .A  (A),
      .K  (K),
      .OW (OW),
      .CW (CW)
   ) u_pipe (
      .clock   (clock),
      .reset   (reset),
      .en      (w_en),
      .i_valid (w_issue),
      .i_tag   (r_ch),
      .i_lx    (w_lx),
      .i_ly    (w_ly),
      .i_lz    (w_lz),
      .i_cos   (w_cos),
      .i_sin   (w_sin),
      .o_valid (w_p2_valid),
      .o_tag   (w_p2_tag),
      .o_l     (w_p2_l),
      .o_m     (w_p2_m),
      .o_n     (w_p2_n)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_ch    <= '0;
         r_l         <= '0;
         r_m         <= '0;
         r_n         <= '0;
      end else if (w_en) begin
         r_out_valid <= w_p2_valid;
         if (w_p2_valid) begin
            r_out_ch   <= w_p2_tag;
            r_out_last <= (w_p2_tag == CW'(NCH - 1));
            r_l        <= w_p2_l;
            r_m        <= w_p2_m;
            r_n        <= w_p2_n;
         end
      end
   end

   assign frame_ready = r_frame_ready;
   assign busy        = r_busy;
   assign out_valid   = r_out_valid;
   assign out_last    = r_out_last;
   assign out_ch      = r_out_ch;
   assign L           = r_l;
   assign M           = r_m;
   assign N           = r_n;

endmodule

// File: doc/servo_lmn_seq.md
# servo_lmn_seq

Multi-channel, time-multiplexed front end for the servo angle path of the ball-and-plate platform. It accepts one frame of NCH leg-length vectors, then computes the per-leg L, M, N terms serially through one shared two-stage arithmetic pipeline. Each leg has its own runtime-tabled servo orientation instead of a fixed compile-time angle. Results are emitted as a tagged valid/ready stream toward the sqrt/atan2 and arcsin stages.

## Interface
- NCH, 6: number of legs/servos per frame (≥1).
- W, 9: signed width of each leg component lx/ly/lz.
- AW, 8: unsigned width of servo horn length A.
- A, 20: servo horn length, same unit as leg components.
- K, 100: unsigned constant S²−A², width 2W.
- COS_TBL, package default: NCH×8-bit signed Q1.6 cos(β_i), channel 0 in LSBs.
- SIN_TBL, package default: NCH×8-bit signed Q1.6 sin(β_i), channel 0 in LSBs.
- Derived localparams: OW = 2W+AW; CW = max(1, clog2(NCH)).
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- frame_valid  in  1  frame on lx_flat/ly_flat/lz_flat is offered.
- frame_ready  out  1  block can accept a frame; high only in IDLE.
- lx_flat, ly_flat, lz_flat  in  NCH·W  signed leg components, channel i at bits [i·W +: W].
- out_valid  out  1  L/M/N/out_ch/out_last hold a result.
- out_ready  in  1  downstream accepts the result.
- out_ch  out  CW  channel index of the current result.
- out_last  out  1  result is channel NCH−1.
- L, M, N  out  OW each  signed results.
- busy  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, RUN, WAIT.
- IDLE: frame_ready=1. On frame_valid, capture all three flat buses into a frame register, clear issue counter ch, and go to RUN.
- RUN: issue channel ch into the pipeline each non-stalled cycle, then ch++. After issuing NCH−1, go to WAIT.
- WAIT: go to IDLE on the edge where the out_last result handshakes.
- Arithmetic, exact with no saturation:
  - L = lx²+ly²+lz² − K.
  - M = 2A·lz.
  - N = (2A·(cos_i·lx + sin_i·ly)) >>> 6, arithmetic shift, i.e. floor.
  - All values are sign-extended to OW; by construction no overflow occurs.
- Pipeline: stage P1 registers the products; stage P2 registers the sums and the shift; the output register holds L/M/N/out_ch/out_last.
- Backpressure: when out_valid && !out_ready, the whole pipeline, the issue counter and the FSM freeze. Frame register contents never change while busy.
- Channel tags and per-stage valid bits travel with the data.
- A new frame_valid while busy is ignored, because frame_ready=0. The source holds it.

## Timing
- Reset values:
  - state IDLE, frame_ready=1, busy=0.
  - out_valid=0, out_last=0, out_ch=0, L=M=N=0.
  - pipeline valids 0, ch=0.
- reset mid-frame discards all in-flight results; no partial frame is emitted afterwards.
- Frame accepted at edge t0. Channel 0 enters P1 at t1 and P2 at t2. out_valid rises after edge t3.
- With out_ready held at 1:
  - one result per cycle, channel i valid after edge t3+i.
  - out_last after edge t3+NCH−1.
  - IDLE and frame_ready=1 after edge t3+NCH.
  - Frame period is NCH+4 cycles.
- out_valid/data are stable until handshake; no combinational path from out_ready to out_valid.
- NCH=1: RUN issues once and goes straight to WAIT; out_last is set on the only result.

## Structure
- Package servo_pkg holds:
  - clog2 function and OW/CW derivation.
  - default 6-leg COS_TBL/SIN_TBL constants.
  - FSM state enum encoding.
- Sub-module lmn_pipe: two-stage enable-gated arithmetic pipeline (inputs lx, ly, lz, cos, sin, valid, tag, en). The top level holds the FSM, frame register, counter and output register.

## Test plan
All cases use A=20, K=100, COS_TBL ch0=64/ch1=0, SIN_TBL ch0=0/ch1=64.
- Basic: leg (10,20,30) on ch0 and ch1, out_ready=1 -> ch0 L=1300 M=1200 N=400; ch1 L=1300 M=1200 N=800; first out_valid 3 cycles after accept.
- Extremes: ch0 (−256,0,−256) -> L=130972, M=−10240, N=−10240; no overflow at OW=26.
- Rounding: cos=sin=45 on ch2. lx=1, ly=0 gives N=28; lx=−1 gives N=−29 (floor).
- Backpressure: out_ready toggles 1,0,0,1 through a 6-channel frame -> results emitted in order 0..5 with values unchanged during stalls; out_last only on ch5; frame_ready low until the last handshake.
- Frame gating: frame_valid held through a busy frame with changing data -> outputs reflect only the captured frame; the second frame is accepted exactly on the cycle after the t3+NCH edge.
- Reset: assert reset with ch3 in the output register -> next cycle out_valid=0, frame_ready=1, L=M=N=0; a new frame produces channel 0 first.
